// File: rtl/fwd_scoreboard_pkg.sv
// fwd_scoreboard_pkg: shared widths, types and constants for the forwarding scoreboard
package fwd_scoreboard_pkg;
   localparam int DEF_XLEN     = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_NUM_SRC  = 2;
   localparam int DEF_NUM_FWD  = 2;
   localparam int DEF_MAX_PEND = 3;
   localparam int DEF_CNT_W    = 32;
   localparam int DEF_RW       = $clog2(DEF_NUM_REGS);
   localparam int DEF_PW       = $clog2(DEF_MAX_PEND + 1);
   typedef logic [DEF_RW-1:0] reg_num_t;
   typedef logic [DEF_PW-1:0] scb_cnt_t;
   typedef struct packed {
      logic                valid;
      reg_num_t            rd;
      logic [DEF_XLEN-1:0] data;
   } fwd_bus_t;
   localparam reg_num_t REG_ZERO = '0;
endpackage

// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: issue, operand, forwarding and writeback signals of the scoreboard
interface fwd_scoreboard_if
   import fwd_scoreboard_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_SRC  = DEF_NUM_SRC,
   parameter int NUM_FWD  = DEF_NUM_FWD,
   parameter int CNT_W    = DEF_CNT_W
);
   localparam int RW = $clog2(NUM_REGS);
   logic                             flush;
   logic                             issue_valid;
   logic                             issue_has_rd;
   logic [RW-1:0]                    issue_rd;
   logic [NUM_SRC-1:0]               src_valid;
   logic [NUM_SRC-1:0][RW-1:0]       src_num;
   logic [NUM_SRC-1:0][XLEN-1:0]     src_rf_value;
   logic [NUM_FWD-1:0]               fwd_valid;
   logic [NUM_FWD-1:0][RW-1:0]       fwd_rd;
   logic [NUM_FWD-1:0][XLEN-1:0]     fwd_data;
   logic                             wb_valid;
   logic [RW-1:0]                    wb_rd;
   logic [NUM_SRC-1:0][XLEN-1:0]     src_value;
   logic                             issue_stall;
   logic                             issue_fire;
   logic [CNT_W-1:0]                 stall_cycles;
   modport master (
      output flush, issue_valid, issue_has_rd, issue_rd, src_valid, src_num, src_rf_value,
             fwd_valid, fwd_rd, fwd_data, wb_valid, wb_rd,
      input  src_value, issue_stall, issue_fire, stall_cycles
   );
   modport slave (
      input  flush, issue_valid, issue_has_rd, issue_rd, src_valid, src_num, src_rf_value,
             fwd_valid, fwd_rd, fwd_data, wb_valid, wb_rd,
      output src_value, issue_stall, issue_fire, stall_cycles
   );
endinterface

// File: rtl/fwd_scoreboard_src_resolve.sv
// scb_src_resolve: one source operand's forwarding priority mux and hazard detect
module scb_src_resolve
   import fwd_scoreboard_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_FWD  = DEF_NUM_FWD,
   localparam int RW      = $clog2(NUM_REGS)
) (
   input  logic                         use_src,
   input  logic [RW-1:0]                num,
   input  logic [XLEN-1:0]              rf_value,
   input  logic                         busy,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD-1:0][RW-1:0]   fwd_rd,
   input  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data,
   output logic [XLEN-1:0]              value,
   output logic                         hazard
);
   logic            need;
   logic            hit;
   logic [XLEN-1:0] fwd_val;
   assign need = use_src && num != RW'(REG_ZERO) && busy;
   // Scan from the oldest bus down so the youngest matching bus wins.
   always_comb begin
      hit = 1'b0;
      fwd_val = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_valid[k] && fwd_rd[k] == num) begin
            hit = 1'b1;
            fwd_val = fwd_data[k];
         end
      end
   end
   assign value  = (need && hit) ? fwd_val : rf_value;
   assign hazard = need && !hit;
endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: per-register pending-write scoreboard with operand forwarding and issue stall
module fwd_scoreboard
   import fwd_scoreboard_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_SRC  = DEF_NUM_SRC,
   parameter int NUM_FWD  = DEF_NUM_FWD,
   parameter int MAX_PEND = DEF_MAX_PEND,
   parameter int CNT_W    = DEF_CNT_W
) (
   input logic             clk,
   input logic             rst_n,
   fwd_scoreboard_if.slave bus
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int PW = $clog2(MAX_PEND + 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
   logic [PW-1:0]                pend     [NUM_REGS];
   logic [PW-1:0]                pend_nxt [NUM_REGS];
   logic [NUM_REGS-1:0]          inc;
   logic [NUM_REGS-1:0]          dec;
   logic [NUM_SRC-1:0]           hazard;
   logic [NUM_SRC-1:0][XLEN-1:0] value;
   logic                         full;
   logic [CNT_W-1:0]             stall_cnt;
   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      scb_src_resolve #(
         .XLEN     (XLEN),
         .NUM_REGS (NUM_REGS),
         .NUM_FWD  (NUM_FWD)
      ) u_resolve (
         .use_src   (bus.src_valid[s]),
         .num       (bus.src_num[s]),
         .rf_value  (bus.src_rf_value[s]),
         .busy      (pend[bus.src_num[s]] != '0),
         .fwd_valid (bus.fwd_valid),
         .fwd_rd    (bus.fwd_rd),
         .fwd_data  (bus.fwd_data),
         .value     (value[s]),
         .hazard    (hazard[s])
      );
   end
   assign full = bus.issue_has_rd && bus.issue_rd != RW'(REG_ZERO) && pend[bus.issue_rd] == PEND_MAX;
   assign bus.src_value    = value;
   assign bus.issue_stall  = bus.issue_valid && (|hazard || full);
   assign bus.issue_fire   = bus.issue_valid && !bus.issue_stall;
   assign bus.stall_cycles = stall_cnt;
   // Register 0 never increments and so never leaves zero.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         inc[r] = bus.issue_fire && bus.issue_has_rd && bus.issue_rd == RW'(r) && r != 0;
         dec[r] = bus.wb_valid && bus.wb_rd == RW'(r) && pend[r] != '0;
         pend_nxt[r] = (inc[r] && !dec[r]) ? pend[r] + 1'b1 :
                       (dec[r] && !inc[r]) ? pend[r] - 1'b1 : pend[r];
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
         stall_cnt <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) pend[r] <= bus.flush ? '0 : pend_nxt[r];
         if (bus.issue_valid && bus.issue_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed and randomized checks of fwd_scoreboard against a behavioural model
module tb_fwd_scoreboard;
   localparam int XL = 32;
   localparam int NR = 32;
   localparam int NS = 2;
   localparam int NF = 2;
   localparam int MP = 3;
   localparam int CW = 32;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int failures = 0;
   int pm [NR];
   logic [CW-1:0] cm;
   bit e_stall;
   fwd_scoreboard_if #(.XLEN(XL), .NUM_REGS(NR), .NUM_SRC(NS), .NUM_FWD(NF), .CNT_W(CW)) bus ();
   fwd_scoreboard #(.XLEN(XL), .NUM_REGS(NR), .NUM_SRC(NS), .NUM_FWD(NF), .MAX_PEND(MP), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask
   task automatic model_reset();
      for (int r = 0; r < NR; r++) pm[r] = 0;
      cm = '0;
   endtask
   task automatic idle();
      bus.flush = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_has_rd = 1'b0;
      bus.issue_rd = '0;
      bus.src_valid = '0;
      bus.src_num = '0;
      bus.src_rf_value = '0;
      bus.fwd_valid = '0;
      bus.fwd_rd = '0;
      bus.fwd_data = '0;
      bus.wb_valid = 1'b0;
      bus.wb_rd = '0;
   endtask
   task automatic issue(input bit has_rd, input int rd);
      bus.issue_valid = 1'b1;
      bus.issue_has_rd = has_rd;
      bus.issue_rd = 5'(rd);
   endtask
   task automatic src(input int s, input int num, input logic [XL-1:0] rf);
      bus.src_valid[s] = 1'b1;
      bus.src_num[s] = 5'(num);
      bus.src_rf_value[s] = rf;
   endtask
   task automatic fwd(input int k, input int rd, input logic [XL-1:0] d);
      bus.fwd_valid[k] = 1'b1;
      bus.fwd_rd[k] = 5'(rd);
      bus.fwd_data[k] = d;
   endtask
   task automatic wb(input int rd);
      bus.wb_valid = 1'b1;
      bus.wb_rd = 5'(rd);
   endtask
   task automatic check_all();
      logic [XL-1:0] ev;
      bit hz;
      bit any_hz;
      #1;
      any_hz = 1'b0;
      for (int s = 0; s < NS; s++) begin
         int n;
         n = int'(bus.src_num[s]);
         ev = bus.src_rf_value[s];
         hz = 1'b0;
         if (bus.src_valid[s] && n != 0 && pm[n] > 0) begin
            hz = 1'b1;
            for (int k = 0; k < NF; k++) begin
               if (bus.fwd_valid[k] && int'(bus.fwd_rd[k]) == n) begin
                  ev = bus.fwd_data[k];
                  hz = 1'b0;
                  break;
               end
            end
         end
         any_hz |= hz;
         if (!hz) chk($sformatf("src%0d_value", s), 64'(bus.src_value[s]), 64'(ev));
      end
      e_stall = bus.issue_valid && (any_hz || (bus.issue_has_rd && bus.issue_rd != 0 && pm[bus.issue_rd] == MP));
      chk("issue_stall", 64'(bus.issue_stall), 64'(e_stall));
      chk("issue_fire", 64'(bus.issue_fire), 64'(bus.issue_valid && !e_stall));
      chk("stall_cycles", 64'(bus.stall_cycles), 64'(cm));
   endtask
   task automatic tick();
      bit fire;
      fire = bus.issue_valid && !e_stall;
      @(posedge clk);
      if (bus.issue_valid && e_stall && cm != '1) cm++;
      if (bus.flush) begin
         for (int r = 0; r < NR; r++) pm[r] = 0;
      end else begin
         for (int r = 1; r < NR; r++) begin
            int d;
            d = 0;
            if (fire && bus.issue_has_rd && int'(bus.issue_rd) == r) d++;
            if (bus.wb_valid && int'(bus.wb_rd) == r && pm[r] > 0) d--;
            pm[r] += d;
         end
      end
      #1;
   endtask
   initial begin
      model_reset();
      e_stall = 1'b0;
      rst_n = 1'b0;
      idle();
      #1;
      chk("reset_stall_cycles", 64'(bus.stall_cycles), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(); issue(1, 5); src(0, 5, 32'h11);
      check_all();
      chk("idle_value", 64'(bus.src_value[0]), 64'h11);
      chk("idle_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); issue(1, 7);
      check_all(); tick();
      idle(); issue(0, 0); src(0, 7, 32'h55); fwd(1, 7, 32'hAB);
      check_all();
      chk("raw_fwd_value", 64'(bus.src_value[0]), 64'hAB);
      chk("raw_fwd_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); issue(0, 0); src(0, 7, 32'h55);
      for (int i = 0; i < 3; i++) begin
         check_all();
         chk("raw_stall", 64'(bus.issue_stall), 64'd1);
         chk("raw_stall_cycles", 64'(bus.stall_cycles), 64'(i));
         tick();
      end
      idle(); issue(1, 3);
      check_all(); tick();
      idle(); issue(0, 0); src(1, 3, 32'h99); fwd(0, 3, 32'h1); fwd(1, 3, 32'h2);
      check_all();
      chk("prio_value", 64'(bus.src_value[1]), 64'h1);
      tick();
      for (int i = 0; i < MP; i++) begin
         idle(); issue(1, 9);
         check_all();
         chk("sat_fill_fire", 64'(bus.issue_fire), 64'd1);
         tick();
      end
      idle(); issue(1, 9);
      check_all();
      chk("sat_full_stall", 64'(bus.issue_stall), 64'd1);
      tick();
      idle(); issue(1, 9); wb(9);
      check_all();
      chk("sat_wb_stall", 64'(bus.issue_stall), 64'd1);
      tick();
      idle(); issue(1, 9);
      check_all();
      chk("sat_resume", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); issue(1, 0);
      check_all();
      chk("x0_write_fire", 64'(bus.issue_fire), 64'd1);
      tick();
      idle(); issue(1, 0); src(0, 0, 32'h0); src(1, 0, 32'h0);
      check_all();
      chk("x0_src_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         idle(); issue(1, 4);
         check_all(); tick();
      end
      idle(); issue(1, 4); bus.flush = 1'b1;
      check_all();
      chk("flush_fire", 64'(bus.issue_fire), 64'd1);
      tick();
      idle(); issue(0, 0); src(0, 4, 32'h44);
      check_all();
      chk("flush_value", 64'(bus.src_value[0]), 64'h44);
      chk("flush_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); issue(0, 0); src(0, 9, 32'h1);
      check_all(); tick();
      check_all(); tick();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_stall_cycles", 64'(bus.stall_cycles), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(); issue(0, 0); src(0, 9, 32'h1);
      check_all();
      chk("post_reset_stall", 64'(bus.issue_stall), 64'd0);
      tick();
      for (int n = 0; n < 600; n++) begin
         bus.issue_valid = $urandom_range(0, 3) != 0;
         bus.issue_has_rd = 1'($urandom_range(0, 1));
         bus.issue_rd = 5'($urandom_range(0, 7));
         bus.src_valid = 2'($urandom_range(0, 3));
         for (int s = 0; s < NS; s++) begin
            bus.src_num[s] = 5'($urandom_range(0, 7));
            bus.src_rf_value[s] = $urandom;
         end
         bus.fwd_valid = 2'($urandom_range(0, 3));
         for (int k = 0; k < NF; k++) begin
            bus.fwd_rd[k] = 5'($urandom_range(0, 7));
            bus.fwd_data[k] = $urandom;
         end
         bus.wb_valid = 1'($urandom_range(0, 1));
         bus.wb_rd = 5'($urandom_range(0, 7));
         bus.flush = $urandom_range(0, 31) == 0;
         check_all();
         tick();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the combinational EX/MEM forwarding and hazard logic.
- Tracks in-flight register writes with per-register pending counters, so variable-latency producers (load, mul, div) and any number of forwarding buses are handled uniformly.
- Sits between decode/issue and execute. Supplies forwarded source operands and a single issue-stall signal, and keeps a stall-cycle performance counter.

Parameters:
- XLEN, 32, data width.
- NUM_REGS, 32, architectural registers; register 0 is hard-wired zero.
- NUM_SRC, 2, source operands per issuing instruction.
- NUM_FWD, 2, forwarding buses; index 0 is the youngest and has the highest priority.
- MAX_PEND, 3, maximum outstanding writes to one register.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; all in-flight writes are killed.
- issue_valid  in  1  an instruction is presented for issue.
- issue_has_rd  in  1  the presented instruction writes a register.
- issue_rd  in  log2(NUM_REGS)  destination register number.
- src_valid  in  NUM_SRC  per-source use flag.
- src_num  in  NUM_SRC x log2(NUM_REGS)  source register numbers.
- src_rf_value  in  NUM_SRC x XLEN  register-file read data.
- fwd_valid  in  NUM_FWD  forwarding bus carries a result this cycle.
- fwd_rd  in  NUM_FWD x log2(NUM_REGS)  destination register on each bus.
- fwd_data  in  NUM_FWD x XLEN  result data on each bus.
- wb_valid  in  1  writeback retiring a write this cycle.
- wb_rd  in  log2(NUM_REGS)  retiring destination register.
- src_value  out  NUM_SRC x XLEN  resolved operand values (combinational).
- issue_stall  out  1  issue must hold this cycle (combinational).
- issue_fire  out  1  equals issue_valid and not issue_stall.
- stall_cycles  out  CNT_W  count of cycles with issue_valid and issue_stall.

Behaviour:
- State:
  - pend[r], width log2(MAX_PEND+1), for r = 1..NUM_REGS-1. pend[0] is constant 0.
  - stall_cycles.
  - Reset (rst_n low, asynchronous): all pend = 0, stall_cycles = 0.
- Pending counter update (per register, per cycle):
  - inc = issue_fire and issue_has_rd and issue_rd == r and r != 0.
  - dec = wb_valid and wb_rd == r and pend[r] > 0.
  - inc and dec together: pend unchanged. inc only: +1. dec only: -1.
  - A wb with pend already 0 is ignored; it never underflows.
- Flush:
  - flush high on a clock edge sets every pend to 0.
  - flush takes priority over any simultaneous inc or dec.
  - issue_fire is still reported combinationally while flush is high, but that issue is not recorded.
  - stall_cycles is not affected by flush.
- Source resolution, per source s:
  - If src_valid[s] is 0, or src_num[s] is 0: value = src_rf_value[s] (the register file returns 0 for register 0). No hazard.
  - Otherwise, if pend[src_num] is 0: value = src_rf_value[s].
  - Otherwise, if any bus has fwd_valid[k] and fwd_rd[k] == src_num: value = fwd_data of the lowest such k. No hazard.
  - Otherwise: hazard[s] = 1 and value = src_rf_value[s] (don't-care).
- Issue stall:
  - issue_stall = issue_valid and (any hazard[s], or (issue_has_rd and issue_rd != 0 and pend[issue_rd] == MAX_PEND)).
  - issue_stall is 0 when issue_valid is 0.
  - Same-cycle writeback: a wb_valid to the sourced register in the same cycle does not clear the hazard. The hazard clears only through a forwarding-bus hit; the retired value is in the register file from the next cycle.
- stall_cycles: increments when issue_valid and issue_stall, and saturates at all-ones.
- Latency: operand forwarding and stall are 0-cycle combinational. Scoreboard updates are visible the cycle after the edge.

Decomposition:
- Shared core package gains:
  - reg_num_t
  - scb_cnt_t
  - fwd_bus_t (valid, rd, data)
  - a constant REG_ZERO = 0
- One sub-module, scb_src_resolve: per-source forwarding priority mux and hazard detect. Instantiate it NUM_SRC times.
- Pending counters and the performance counter stay in the top module.

Test Plan:
- Reset then idle:
  - Stimulus: issue x5 with src x5 at pend 0 and src_rf_value = 0x11.
  - Required: src_value = 0x11, issue_stall = 0.
- RAW through a bus:
  - Stimulus: issue writes x7, then next cycle sources x7 with fwd_valid[1] = 1, fwd_rd[1] = 7, fwd_data[1] = 0xAB.
  - Required: src_value = 0xAB, no stall.
  - Repeat with fwd_valid = 0. Required: stall, and stall_cycles increments each cycle.
- Priority:
  - Stimulus: both buses hit x3 (data 0x1 on bus 0, 0x2 on bus 1).
  - Required: src_value = 0x1.
- Saturation:
  - Stimulus: MAX_PEND = 3 issues to x9 with no wb.
  - Required: the fourth issue to x9 stalls. A wb x9 in the same cycle still stalls; the issue proceeds the next cycle once pend = 2.
- x0:
  - Stimulus: issue writes x0, then source x0.
  - Required: pend stays 0, no stall.
- Flush and reset:
  - Stimulus: pend[4] = 2, assert flush.
  - Required: next cycle, sourcing x4 yields src_rf_value with no stall.
  - Stimulus: assert rst_n low mid-stall.
  - Required: stall_cycles = 0 immediately (asynchronous).
